// File: rtl/jtag_pkg.sv
// TAP controller shared types: state encoding, next-state function, opcode defaults.
package jtag_pkg;

  localparam int unsigned IDCODE_W      = 32;
  localparam int unsigned DEF_OP_IDCODE = 1;
  localparam int unsigned DEF_OP_USER   = 2;
  localparam logic [1:0]  IR_CAP_PAT    = 2'b01;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PA_DR  = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PA_IR  = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_e;

  // TAP state transition keyed by the sampled tms value.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PA_DR;
      PA_DR:  n = tms ? EX2_DR : PA_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PA_IR;
      PA_IR:  n = tms ? EX2_IR : PA_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_if.sv
// JTAG pin set plus the user-DR parallel port; master drives pins, slave is the TAP.
interface jtag_if import jtag_pkg::*; #(
  parameter int unsigned IR_W = 4,
  parameter int unsigned DR_W = 32
) ();

  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic [IR_W-1:0] ir_q;
  tap_state_e      tap_state;
  logic [DR_W-1:0] usr_cap_data;
  logic [DR_W-1:0] usr_upd_data;
  logic            usr_upd;

  modport master_mp (
    output tms, tdi, usr_cap_data,
    input  tdo, tdo_en, ir_q, tap_state, usr_upd_data, usr_upd
  );

  modport slave_mp (
    input  tms, tdi, usr_cap_data,
    output tdo, tdo_en, ir_q, tap_state, usr_upd_data, usr_upd
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state register.
module jtag_tap_fsm import jtag_pkg::*; (
  input  logic       i_tck,
  input  logic       i_trst,
  input  logic       i_tms,
  output tap_state_e o_state,
  output tap_state_e o_state_nxt_c
);

  tap_state_e r_state;

  assign o_state_nxt_c = tap_next(r_state, i_tms);
  assign o_state       = r_state;

  // Advance on every tck edge; trst parks the controller in Test-Logic-Reset.
  always_ff @(posedge i_tck or negedge i_trst) begin
    if (!i_trst) r_state <= TLR;
    else         r_state <= o_state_nxt_c;
  end

endmodule

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP: instruction register, BYPASS/IDCODE/user DRs, update port and tdo.
module jtag_tap import jtag_pkg::*; #(
  parameter int unsigned     IR_W       = 4,
  parameter int unsigned     DR_W       = 32,
  parameter logic [31:0]     IDCODE_VAL = 32'h1234_5679,
  parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(DEF_OP_IDCODE),
  parameter logic [IR_W-1:0] OP_USER    = IR_W'(DEF_OP_USER)
) (
  input logic       tck,
  input logic       trst,
  jtag_if.slave_mp  bus
);

  tap_state_e          w_state;
  tap_state_e          w_state_nxt;
  logic [IR_W-1:0]     r_ir_sh;
  logic [IR_W-1:0]     r_ir_q;
  logic [IR_W-1:0]     w_ir_shifted;
  logic                r_byp;
  logic [IDCODE_W-1:0] r_id_sh;
  logic [IDCODE_W-1:0] w_id_shifted;
  logic [DR_W-1:0]     r_usr_sh;
  logic [DR_W-1:0]     w_usr_shifted;
  logic [DR_W-1:0]     r_upd_data;
  logic                r_upd;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                w_sel_id;
  logic                w_sel_usr;
  logic                w_tdo_bit;

  jtag_tap_fsm u_fsm (
    .i_tck         (tck),
    .i_trst        (trst),
    .i_tms         (bus.tms),
    .o_state       (w_state),
    .o_state_nxt_c (w_state_nxt)
  );

  assign w_sel_id  = (r_ir_q == OP_IDCODE);
  assign w_sel_usr = (r_ir_q == OP_USER) && !w_sel_id;

  // Right-shift images with tdi entering the MSB (width-agnostic, DR_W may be 1).
  always_comb begin
    w_ir_shifted                 = r_ir_sh >> 1;
    w_ir_shifted[IR_W-1]         = bus.tdi;
    w_id_shifted                 = r_id_sh >> 1;
    w_id_shifted[IDCODE_W-1]     = bus.tdi;
    w_usr_shifted                = r_usr_sh >> 1;
    w_usr_shifted[DR_W-1]        = bus.tdi;
  end

  // Instruction register: capture/shift, then commit on leaving UPD_IR; TLR restores IDCODE.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_ir_sh <= '0;
      r_ir_q  <= OP_IDCODE;
    end else begin
      case (w_state)
        CAP_IR:  r_ir_sh <= IR_W'(IR_CAP_PAT);
        SH_IR:   r_ir_sh <= w_ir_shifted;
        default: ;
      endcase
      if (w_state_nxt == TLR)     r_ir_q <= OP_IDCODE;
      else if (w_state == UPD_IR) r_ir_q <= r_ir_sh;
    end
  end

  // Data registers: only the one selected by the current instruction captures or shifts.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_byp    <= 1'b0;
      r_id_sh  <= '0;
      r_usr_sh <= '0;
    end else if (w_state == CAP_DR) begin
      if (w_sel_id)       r_id_sh  <= IDCODE_VAL;
      else if (w_sel_usr) r_usr_sh <= bus.usr_cap_data;
      else                r_byp    <= 1'b0;
    end else if (w_state == SH_DR) begin
      if (w_sel_id)       r_id_sh  <= w_id_shifted;
      else if (w_sel_usr) r_usr_sh <= w_usr_shifted;
      else                r_byp    <= bus.tdi;
    end
  end

  // User update register and its one-cycle strobe, taken on the edge leaving UPD_DR.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_upd_data <= '0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_state == UPD_DR && w_sel_usr) begin
        r_upd_data <= r_usr_sh;
        r_upd      <= 1'b1;
      end
    end
  end

  // Serial output source for the current shift state.
  always_comb begin
    w_tdo_bit = r_byp;
    if (w_state == SH_IR)  w_tdo_bit = r_ir_sh[0];
    else if (w_sel_id)     w_tdo_bit = r_id_sh[0];
    else if (w_sel_usr)    w_tdo_bit = r_usr_sh[0];
  end

  // tdo launches on the falling edge; it holds its value outside the shift states.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_state == SH_IR || w_state == SH_DR) begin
      r_tdo    <= w_tdo_bit;
      r_tdo_en <= 1'b1;
    end else begin
      r_tdo_en <= 1'b0;
    end
  end

  assign bus.tdo          = r_tdo;
  assign bus.tdo_en       = r_tdo_en;
  assign bus.ir_q         = r_ir_q;
  assign bus.tap_state    = w_state;
  assign bus.usr_upd_data = r_upd_data;
  assign bus.usr_upd      = r_upd;

endmodule

// File: tb/tb_jtag_tap.sv
// Bench for jtag_tap: vector table, directed corner sequences, random run against a queue model.
module tb_jtag_tap;
  import jtag_pkg::*;

  logic tck;
  logic trst;
  int   n_chk;
  int   n_err;

  jtag_if #(.IR_W(4), .DR_W(32)) bus ();

  jtag_tap #(
    .IR_W(4), .DR_W(32), .IDCODE_VAL(32'h1234_5679),
    .OP_IDCODE(4'h1), .OP_USER(4'h2)
  ) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       tms;
    logic       tdi;
    tap_state_e st;
    logic [3:0] ir;
    logic       en;
    logic       tdo;
  } vec_t;

  vec_t tbl[$];

  // Model state: index into the state list in the order the standard names them.
  tap_state_e enc[16] = '{TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                          SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR};
  int          m_st;
  int          m_ir;
  bit          m_irq[$];
  bit          m_dr[$];
  logic [31:0] m_upd_data;
  bit          m_upd;
  bit          m_tdo;
  bit          m_en;
  logic [31:0] idc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic t, input logic d, input tap_state_e st,
                     input logic [3:0] ir, input logic en, input logic tdo);
    vec_t v;
    v.tms = t; v.tdi = d; v.st = st; v.ir = ir; v.en = en; v.tdo = tdo;
    tbl.push_back(v);
  endtask

  task automatic step(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic reset_dut();
    trst = 1'b0;
    bus.tms = 1'b1;
    @(posedge tck);
    @(negedge tck);
    #1;
    trst = 1'b1;
  endtask

  // From RTI: load an instruction, return the bits that came out of tdo; ends in RTI.
  task automatic load_ir(input logic [3:0] v, output logic [3:0] out);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      out[i] = bus.tdo;
      step(i == 3, v[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI: 32-bit DR scan ending in EX1_DR, optional 3-cycle pause after bit pause_at.
  task automatic shift_dr(input logic [31:0] din, input int pause_at,
                          output logic [31:0] dout, output int en_bad);
    en_bad = 0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      dout[i] = bus.tdo;
      if (bus.tdo_en !== 1'b1) en_bad++;
      if (i == 31) step(1'b1, din[i]);
      else if (i == pause_at) begin
        step(1'b1, din[i]);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end else step(1'b0, din[i]);
    end
  endtask

  function automatic int mnext(input int s, input bit t);
    int b;
    int k;
    if (s == 0) return t ? 0 : 1;
    if (s == 1) return t ? 2 : 1;
    if (s == 2) return t ? 9 : 3;
    if (s == 9) return t ? 0 : 10;
    b = (s < 9) ? 2 : 9;
    k = s - b;
    case (k)
      1, 2:    return t ? b + 3 : b + 2;
      3:       return t ? b + 6 : b + 4;
      4:       return t ? b + 5 : b + 4;
      5:       return t ? b + 6 : b + 2;
      default: return t ? 2 : 1;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_ir = 1; m_irq.delete(); m_dr.delete();
    m_upd_data = '0; m_upd = 0; m_tdo = 0; m_en = 0;
  endtask

  task automatic model_step(input bit t, input bit d, input logic [31:0] cap);
    int s;
    s = m_st;
    m_upd = 0;
    if (s == 10) begin
      m_irq.delete();
      for (int i = 0; i < 4; i++) m_irq.push_back(i == 0);
    end
    if (s == 11) begin m_irq.push_back(d); void'(m_irq.pop_front()); end
    if (s == 3) begin
      m_dr.delete();
      if (m_ir == 1)      for (int i = 0; i < 32; i++) m_dr.push_back(idc[i]);
      else if (m_ir == 2) for (int i = 0; i < 32; i++) m_dr.push_back(cap[i]);
      else                m_dr.push_back(1'b0);
    end
    if (s == 4) begin m_dr.push_back(d); void'(m_dr.pop_front()); end
    if (s == 8 && m_ir == 2) begin
      for (int i = 0; i < 32; i++) m_upd_data[i] = m_dr[i];
      m_upd = 1;
    end
    if (s == 15) begin
      m_ir = 0;
      for (int i = 0; i < 4; i++) if (m_irq[i]) m_ir += (1 << i);
    end
    m_st = mnext(s, t);
    if (m_st == 0) m_ir = 1;
    if (m_st == 4)       begin m_tdo = m_dr[0];  m_en = 1; end
    else if (m_st == 11) begin m_tdo = m_irq[0]; m_en = 1; end
    else m_en = 0;
  endtask

  initial begin
    logic [3:0]  irout;
    logic [31:0] dout;
    int          en_bad;
    int          pulses;
    logic [3:0]  tgt;
    int          k_ir;
    logic        tv;
    logic        dv;
    logic [31:0] cap;

    n_chk = 0; n_err = 0;
    idc = 32'h1234_5679;
    trst = 1'b0; bus.tms = 1'b1; bus.tdi = 1'b0; bus.usr_cap_data = '0;
    tgt = 4'h2; k_ir = 0;

    // IR=F then bypass scan, IR=7 then bypass scan
    add(0,0,RTI,4'h1,0,0);    add(1,0,SEL_DR,4'h1,0,0); add(1,0,SEL_IR,4'h1,0,0);
    add(0,0,CAP_IR,4'h1,0,0); add(0,0,SH_IR,4'h1,1,1);  add(0,1,SH_IR,4'h1,1,0);
    add(0,1,SH_IR,4'h1,1,0);  add(0,1,SH_IR,4'h1,1,0);  add(1,1,EX1_IR,4'h1,0,0);
    add(1,0,UPD_IR,4'h1,0,0); add(0,0,RTI,4'hF,0,0);    add(1,0,SEL_DR,4'hF,0,0);
    add(0,0,CAP_DR,4'hF,0,0); add(0,0,SH_DR,4'hF,1,0);  add(0,1,SH_DR,4'hF,1,1);
    add(0,0,SH_DR,4'hF,1,0);  add(0,1,SH_DR,4'hF,1,1);  add(1,1,EX1_DR,4'hF,0,1);
    add(1,0,UPD_DR,4'hF,0,1); add(0,0,RTI,4'hF,0,1);
    add(1,0,SEL_DR,4'hF,0,1); add(1,0,SEL_IR,4'hF,0,1); add(0,0,CAP_IR,4'hF,0,1);
    add(0,0,SH_IR,4'hF,1,1);  add(0,1,SH_IR,4'hF,1,0);  add(0,1,SH_IR,4'hF,1,0);
    add(0,1,SH_IR,4'hF,1,0);  add(1,0,EX1_IR,4'hF,0,0); add(1,0,UPD_IR,4'hF,0,0);
    add(0,0,RTI,4'h7,0,0);    add(1,0,SEL_DR,4'h7,0,0); add(0,0,CAP_DR,4'h7,0,0);
    add(0,0,SH_DR,4'h7,1,0);  add(0,1,SH_DR,4'h7,1,1);  add(0,0,SH_DR,4'h7,1,0);
    add(0,1,SH_DR,4'h7,1,1);  add(1,1,EX1_DR,4'h7,0,1); add(1,0,UPD_DR,4'h7,0,1);
    add(0,0,RTI,4'h7,0,1);

    reset_dut();
    chk("rst state", 32'(bus.tap_state), 32'(TLR));
    chk("rst ir", 32'(bus.ir_q), 32'h1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].tms, tbl[i].tdi);
      chk($sformatf("vec%0d state", i), 32'(bus.tap_state), 32'(tbl[i].st));
      chk($sformatf("vec%0d ir", i), 32'(bus.ir_q), 32'(tbl[i].ir));
      chk($sformatf("vec%0d tdo_en", i), 32'(bus.tdo_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d tdo", i), 32'(bus.tdo), 32'(tbl[i].tdo));
      chk($sformatf("vec%0d usr_upd", i), 32'(bus.usr_upd), 32'h0);
    end

    // IDCODE read after reset
    reset_dut();
    step(1'b0, 1'b0);
    shift_dr(32'h0, -1, dout, en_bad);
    chk("idcode data", dout, 32'h1234_5679);
    chk("idcode tdo_en", 32'(en_bad), 32'h0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("idcode no upd", 32'(bus.usr_upd), 32'h0);
    chk("idcode upd_data", bus.usr_upd_data, 32'h0);

    // user DR capture/update with pause mid-scan
    load_ir(4'h2, irout);
    chk("ir capture", 32'(irout), 32'h1);
    chk("ir user", 32'(bus.ir_q), 32'h2);
    bus.usr_cap_data = 32'hDEAD_BEEF;
    shift_dr(32'hA5A5_5A5A, 15, dout, en_bad);
    chk("user cap data", dout, 32'hDEAD_BEEF);
    chk("user tdo_en", 32'(en_bad), 32'h0);
    step(1'b1, 1'b0);
    chk("upd before exit", 32'(bus.usr_upd), 32'h0);
    step(1'b0, 1'b0);
    chk("upd pulse", 32'(bus.usr_upd), 32'h1);
    chk("upd data", bus.usr_upd_data, 32'hA5A5_5A5A);
    step(1'b0, 1'b0);
    chk("upd pulse end", 32'(bus.usr_upd), 32'h0);

    // five tms=1 from SH_DR; path crosses UPD_DR with one bit shifted
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("sh_dr reached", 32'(bus.tap_state), 32'(SH_DR));
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (bus.usr_upd === 1'b1) pulses++;
    end
    chk("tms5 state", 32'(bus.tap_state), 32'(TLR));
    chk("tms5 ir", 32'(bus.ir_q), 32'h1);
    chk("tms5 pulses", 32'(pulses), 32'h1);
    chk("tms5 upd data", bus.usr_upd_data, 32'h6F56_DF77);

    // trst mid-shift discards the scan
    step(1'b0, 1'b0);
    load_ir(4'h2, irout);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)));
    #2 trst = 1'b0;
    #1;
    chk("trst shift state", 32'(bus.tap_state), 32'(TLR));
    chk("trst shift ir", 32'(bus.ir_q), 32'h1);
    chk("trst shift upd_data", bus.usr_upd_data, 32'h0);
    chk("trst shift upd", 32'(bus.usr_upd), 32'h0);
    chk("trst shift tdo_en", 32'(bus.tdo_en), 32'h0);
    @(negedge tck); #1;
    trst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      if (bus.usr_upd === 1'b1) pulses++;
    end
    chk("trst shift pulses", 32'(pulses), 32'h0);

    // asynchronous trst in RTI after a completed update
    step(1'b0, 1'b0);
    load_ir(4'h2, irout);
    shift_dr(32'h1357_9BDF, -1, dout, en_bad);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("pre-rst upd data", bus.usr_upd_data, 32'h1357_9BDF);
    load_ir(4'h7, irout);
    chk("pre-rst ir", 32'(bus.ir_q), 32'h7);
    #2 trst = 1'b0;
    #1;
    chk("async state", 32'(bus.tap_state), 32'(TLR));
    chk("async ir", 32'(bus.ir_q), 32'h1);
    chk("async tdo_en", 32'(bus.tdo_en), 32'h0);
    chk("async tdo", 32'(bus.tdo), 32'h0);
    chk("async upd_data", bus.usr_upd_data, 32'h0);
    @(negedge tck); #1;
    trst = 1'b1;

    // random walk against the model
    reset_dut();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_st == 10) begin
        case ($urandom_range(0, 3))
          0:       tgt = 4'h1;
          1, 2:    tgt = 4'h2;
          default: tgt = 4'($urandom_range(0, 15));
        endcase
        k_ir = 0;
      end
      if (m_st == 11) begin
        tv = (k_ir >= 3) && ($urandom_range(0, 2) == 0);
        dv = tgt[k_ir % 4];
        k_ir++;
      end else begin
        tv = ($urandom_range(0, 3) == 0);
        dv = 1'($urandom_range(0, 1));
      end
      cap = $urandom;
      bus.usr_cap_data = cap;
      model_step(tv, dv, cap);
      step(tv, dv);
      chk($sformatf("rnd%0d state", n), 32'(bus.tap_state), 32'(enc[m_st]));
      chk($sformatf("rnd%0d ir", n), 32'(bus.ir_q), 32'(m_ir));
      chk($sformatf("rnd%0d tdo_en", n), 32'(bus.tdo_en), 32'(m_en));
      chk($sformatf("rnd%0d tdo", n), 32'(bus.tdo), 32'(m_tdo));
      chk($sformatf("rnd%0d usr_upd", n), 32'(bus.usr_upd), 32'(m_upd));
      chk($sformatf("rnd%0d upd_data", n), bus.usr_upd_data, m_upd_data);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
